// File: rtl/cu_pkg.sv
// cu_pkg: shared constants for the control unit slice.
// Holds opcode values, instruction field positions, FSM state encodings and
// the decoded operation-class type used between cu_decode and control_unit.
package cu_pkg;

    localparam int unsigned DataW    = 16;
    localparam int unsigned RegAddrW = 4;
    localparam int unsigned AddrFldW = 8;

    // Instruction field LSB positions; all register/imm fields are 4 bits wide.
    localparam int unsigned OpLsb   = 12;
    localparam int unsigned RdLsb   = 8;
    localparam int unsigned RaLsb   = 4;
    localparam int unsigned RbLsb   = 0;
    localparam int unsigned AddrLsb = 0;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAddi = 4'h3;
    localparam logic [3:0] OpLd   = 4'h4;
    localparam logic [3:0] OpSt   = 4'h5;
    localparam logic [3:0] OpJmp  = 4'h6;
    localparam logic [3:0] OpBeqz = 4'h7;
    localparam logic [3:0] OpHalt = 4'hF;

    // FSM state encodings.
    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    typedef enum logic [3:0] {
        ClsNop,
        ClsAdd,
        ClsSub,
        ClsAddi,
        ClsLd,
        ClsSt,
        ClsJmp,
        ClsBeqz,
        ClsHalt
    } op_class_e;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: bundles the fetch bus and datapath control signals.
//   master: the control unit (drives pc, fetch request, register addresses,
//           memory address and strobes; receives instr, instr_valid, src1).
//   slave:  instruction memory / datapath side (the mirror image).
interface control_unit_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);
    import cu_pkg::*;

    logic [INSTR_W-1:0]  instr;
    logic                instr_valid;
    logic [DataW-1:0]    src1;
    logic [ADDR_W-1:0]   pc;
    logic                instr_req;
    logic [RegAddrW-1:0] read_reg1;
    logic [RegAddrW-1:0] read_reg2;
    logic [RegAddrW-1:0] write_reg;
    logic [3:0]          alu_imm_val;
    logic [ADDR_W-1:0]   address;
    logic                we;
    logic                mem_store;
    logic                mem_load;
    logic                alu_imm;
    logic                alu_slc;
    logic                halted;

    modport master (
        input  instr, instr_valid, src1,
        output pc, instr_req, read_reg1, read_reg2, write_reg, alu_imm_val, address,
               we, mem_store, mem_load, alu_imm, alu_slc, halted
    );

    modport slave (
        output instr, instr_valid, src1,
        input  pc, instr_req, read_reg1, read_reg2, write_reg, alu_imm_val, address,
               we, mem_store, mem_load, alu_imm, alu_slc, halted
    );

endinterface

// File: rtl/cu_decode.sv
// cu_decode: purely combinational instruction decoder.
//   ir   - latched instruction word
//   cls  - operation class (opcodes 8..E decode as NOP)
//   rd, ra, rb - register fields [11:8], [7:4], [3:0]
//   imm  - immediate field [3:0]
//   addr - memory / jump / branch target field [7:0]
module cu_decode import cu_pkg::*; #(
    parameter int unsigned INSTR_W = 16
) (
    input  logic [INSTR_W-1:0]  ir,
    output op_class_e           cls,
    output logic [RegAddrW-1:0] rd,
    output logic [RegAddrW-1:0] ra,
    output logic [RegAddrW-1:0] rb,
    output logic [3:0]          imm,
    output logic [AddrFldW-1:0] addr
);

    logic [3:0] op;

    assign op   = ir[OpLsb +: 4];
    assign rd   = ir[RdLsb +: RegAddrW];
    assign ra   = ir[RaLsb +: RegAddrW];
    assign rb   = ir[RbLsb +: RegAddrW];
    assign imm  = ir[RbLsb +: 4];
    assign addr = ir[AddrLsb +: AddrFldW];

    always_comb begin
        cls = ClsNop;
        case (op)
            OpAdd:   cls = ClsAdd;
            OpSub:   cls = ClsSub;
            OpAddi:  cls = ClsAddi;
            OpLd:    cls = ClsLd;
            OpSt:    cls = ClsSt;
            OpJmp:   cls = ClsJmp;
            OpBeqz:  cls = ClsBeqz;
            OpHalt:  cls = ClsHalt;
            default: cls = ClsNop;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT sequencer.
//   reg_clc   - clock (rising edge)
//   reg_reset - asynchronous active-high reset
//   bus       - control_unit_if.master: fetch handshake (pc, instr_req,
//               instr, instr_valid), src1 for BEQZ, register addresses,
//               ALU controls, data-memory address and we/mem_load/mem_store
//               strobes, halted flag.
module control_unit import cu_pkg::*; #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic          reg_clc,
    input  logic          reg_reset,
    control_unit_if.master bus
);

    logic [2:0]          state_q, state_d;
    logic [INSTR_W-1:0]  ir_q;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                ir_load;

    op_class_e           cls;
    logic [RegAddrW-1:0] rd, ra, rb;
    logic [3:0]          imm;
    logic [AddrFldW-1:0] addr;

    cu_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .ir   (ir_q),
        .cls  (cls),
        .rd   (rd),
        .ra   (ra),
        .rb   (rb),
        .imm  (imm),
        .addr (addr)
    );

    always_ff @(posedge reg_clc or posedge reg_reset) begin
        if (reg_reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) begin
                ir_q <= bus.instr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_load = 1'b0;
        case (state_q)
            StFetch: begin
                if (bus.instr_valid) begin
                    ir_load = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);  // wraps naturally
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                unique case (cls)
                    ClsAdd, ClsSub, ClsAddi: state_d = StWb;
                    ClsLd, ClsSt:            state_d = StMem;
                    ClsJmp: begin
                        pc_d    = ADDR_W'(addr);
                        state_d = StFetch;
                    end
                    ClsBeqz: begin
                        // pc already points past the branch when not taken
                        if (bus.src1 == '0) begin
                            pc_d = ADDR_W'(addr);
                        end
                        state_d = StFetch;
                    end
                    ClsHalt: state_d = StHalt;
                    default: state_d = StFetch;
                endcase
            end
            StMem:   state_d = (cls == ClsLd) ? StWb : StFetch;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Register addresses come straight from IR, so they are stable from DECODE
    // to the end of the instruction and zero while IR is cleared by reset.
    assign bus.pc          = pc_q;
    assign bus.instr_req   = (state_q == StFetch);
    assign bus.read_reg1   = (cls == ClsSt || cls == ClsBeqz) ? rd : ra;
    assign bus.read_reg2   = rb;
    assign bus.write_reg   = rd;
    assign bus.alu_imm_val = imm;
    assign bus.alu_slc     = (state_q == StExec) && (cls == ClsSub);
    assign bus.alu_imm     = (state_q == StExec) && (cls == ClsAddi);
    assign bus.address     = (state_q == StMem) ? ADDR_W'(addr) : '0;
    assign bus.mem_load    = (state_q == StMem) && (cls == ClsLd);
    assign bus.mem_store   = (state_q == StMem) && (cls == ClsSt);
    assign bus.we          = (state_q == StWb);
    assign bus.halted      = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    control_unit #(
        .ADDR_W  (8),
        .INSTR_W (16)
    ) dut (
        .reg_clc   (clk),
        .reg_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH; returns one cycle later in DECODE.
    task automatic fetch(input logic [15:0] w);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.src1        = '0;

        // Reset held
        #12;
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_we", 32'(bus.we), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_rr1", 32'(bus.read_reg1), 32'h0);
        chk("rst_addr", 32'(bus.address), 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("post_rst_req", 32'(bus.instr_req), 32'h1);

        // ADD r3 = r1 + r2
        fetch(16'h1312);
        chk("add_dec_rr1", 32'(bus.read_reg1), 32'h1);
        chk("add_dec_rr2", 32'(bus.read_reg2), 32'h2);
        chk("add_pc", 32'(bus.pc), 32'h1);
        chk("add_dec_req", 32'(bus.instr_req), 32'h0);
        tick();
        chk("add_ex_slc", 32'(bus.alu_slc), 32'h0);
        chk("add_ex_we", 32'(bus.we), 32'h0);
        tick();
        chk("add_wb_we", 32'(bus.we), 32'h1);
        chk("add_wb_wr", 32'(bus.write_reg), 32'h3);
        tick();
        chk("add_done_we", 32'(bus.we), 32'h0);
        chk("add_done_req", 32'(bus.instr_req), 32'h1);

        // SUB r4 = r5 - r6
        fetch(16'h2456);
        tick();
        chk("sub_ex_slc", 32'(bus.alu_slc), 32'h1);
        chk("sub_ex_imm", 32'(bus.alu_imm), 32'h0);
        tick();
        chk("sub_wb_wr", 32'(bus.write_reg), 32'h4);
        tick();
        chk("sub_done_req", 32'(bus.instr_req), 32'h1);

        // ADDI r2 = r0 + 5
        fetch(16'h3205);
        tick();
        chk("addi_ex_imm", 32'(bus.alu_imm), 32'h1);
        chk("addi_ex_val", 32'(bus.alu_imm_val), 32'h5);
        chk("addi_ex_slc", 32'(bus.alu_slc), 32'h0);
        tick();
        chk("addi_wb_we", 32'(bus.we), 32'h1);
        chk("addi_wb_wr", 32'(bus.write_reg), 32'h2);
        tick();
        chk("addi_pc", 32'(bus.pc), 32'h3);

        // LD rA <- [0x40]
        fetch(16'h4A40);
        tick();
        chk("ld_ex_load", 32'(bus.mem_load), 32'h0);
        tick();
        chk("ld_mem_load", 32'(bus.mem_load), 32'h1);
        chk("ld_mem_addr", 32'(bus.address), 32'h40);
        chk("ld_mem_we", 32'(bus.we), 32'h0);
        chk("ld_mem_store", 32'(bus.mem_store), 32'h0);
        tick();
        chk("ld_wb_we", 32'(bus.we), 32'h1);
        chk("ld_wb_wr", 32'(bus.write_reg), 32'hA);
        chk("ld_wb_load", 32'(bus.mem_load), 32'h0);
        tick();
        chk("ld_done_req", 32'(bus.instr_req), 32'h1);
        chk("ld_pc", 32'(bus.pc), 32'h4);

        // ST rB -> [0x41]
        fetch(16'h5B41);
        chk("st_dec_rr1", 32'(bus.read_reg1), 32'hB);
        tick();
        tick();
        chk("st_mem_store", 32'(bus.mem_store), 32'h1);
        chk("st_mem_addr", 32'(bus.address), 32'h41);
        chk("st_mem_rr1", 32'(bus.read_reg1), 32'hB);
        chk("st_mem_we", 32'(bus.we), 32'h0);
        chk("st_mem_load", 32'(bus.mem_load), 32'h0);
        tick();
        chk("st_done_req", 32'(bus.instr_req), 32'h1);
        chk("st_done_we", 32'(bus.we), 32'h0);
        chk("st_done_store", 32'(bus.mem_store), 32'h0);

        // BEQZ r1, 0x90 taken
        bus.src1 = 16'h0000;
        fetch(16'h7190);
        chk("beqz_dec_rr1", 32'(bus.read_reg1), 32'h1);
        chk("beqz_inc_pc", 32'(bus.pc), 32'h6);
        tick();
        tick();
        chk("beqz_t_req", 32'(bus.instr_req), 32'h1);
        chk("beqz_t_pc", 32'(bus.pc), 32'h90);

        // BEQZ not taken
        bus.src1 = 16'h0001;
        fetch(16'h7190);
        tick();
        tick();
        chk("beqz_nt_req", 32'(bus.instr_req), 32'h1);
        chk("beqz_nt_pc", 32'(bus.pc), 32'h91);
        bus.src1 = 16'h0000;

        // Undefined opcode 9 behaves as NOP
        fetch(16'h9ABC);
        tick();
        chk("undef_ex_imm", 32'(bus.alu_imm), 32'h0);
        chk("undef_ex_slc", 32'(bus.alu_slc), 32'h0);
        tick();
        chk("undef_done_req", 32'(bus.instr_req), 32'h1);
        chk("undef_pc", 32'(bus.pc), 32'h92);

        // Stall in FETCH
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", 32'(bus.pc), 32'h92);
            chk("stall_req", 32'(bus.instr_req), 32'h1);
        end

        // JMP 0xFF then wrap on the next fetch
        fetch(16'h60FF);
        chk("jmp_inc_pc", 32'(bus.pc), 32'h93);
        tick();
        tick();
        chk("jmp_req", 32'(bus.instr_req), 32'h1);
        chk("jmp_pc", 32'(bus.pc), 32'hFF);
        fetch(16'h0000);
        chk("wrap_pc", 32'(bus.pc), 32'h00);
        tick();
        tick();
        chk("nop_done_req", 32'(bus.instr_req), 32'h1);

        // Reset asserted in WB of an ADD
        fetch(16'h1312);
        chk("pre_rst_pc", 32'(bus.pc), 32'h1);
        tick();
        tick();
        chk("pre_rst_we", 32'(bus.we), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.we), 32'h0);
        chk("mid_rst_pc", 32'(bus.pc), 32'h0);
        chk("mid_rst_wr", 32'(bus.write_reg), 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("after_rst_we", 32'(bus.we), 32'h0);
        chk("after_rst_req", 32'(bus.instr_req), 32'h1);
        chk("after_rst_pc", 32'(bus.pc), 32'h0);

        // HALT, then ignore instr_valid until reset
        fetch(16'hF000);
        tick();
        chk("halt_ex_halted", 32'(bus.halted), 32'h0);
        tick();
        chk("halt_halted", 32'(bus.halted), 32'h1);
        chk("halt_req", 32'(bus.instr_req), 32'h0);
        bus.instr       = 16'h1312;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_hold", 32'(bus.halted), 32'h1);
            chk("halt_hold_we", 32'(bus.we), 32'h0);
        end
        chk("halt_pc", 32'(bus.pc), 32'h1);
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst", 32'(bus.halted), 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("halt_rst_req", 32'(bus.instr_req), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
